// File: rtl/string_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : string_sched_pkg
// Purpose : Shared types and constants for the StringCounter scheduler:
//           FSM state encoding, default chunk/result widths, timer width.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package string_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int DATA_W_DEF = 128;
  localparam int OUT_W_DEF  = 160;
  localparam int TIMER_W    = 8;

endpackage

`default_nettype wire

// File: rtl/string_counter_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Purpose : Combinational round-robin arbiter. Searches the request vector
//           starting at the requester just after last_gnt and wraps around.
// Ports   : req      - request vector, one bit per requester
//           last_gnt - index of the most recently served requester
//           gnt      - one-hot grant (all zero when nothing requests)
//           gnt_idx  - encoded index of the granted requester
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int  cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Offset 1..NREQ: the previous winner is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_gnt) + k) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/string_counter_sched.sv
//------------------------------------------------------------------------------
// Module  : string_counter_sched
// Purpose : Shares one StringCounter among NREQ requesters. A requester keeps
//           the grant for a whole chunk sequence; the counter is cleared
//           before each sequence, fed one chunk at a time, and its result (or
//           a timeout error) is returned to the requester.
// Ports   : clk, reset_n           - clock, async active-low reset
//           req_valid/data/last    - per-requester chunk offer
//           req_ready              - per-requester accept (at most one high)
//           rsp_valid/ready        - result handshake
//           rsp_data/id/err        - result word, owner, timeout flag
//           sc_instring/enable/reset - drive to StringCounter
//           sc_out/sc_write        - result from StringCounter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module string_counter_sched
  import string_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OUT_W-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         sc_instring,
  output logic                      sc_enable,
  output logic                      sc_reset,
  input  logic [OUT_W-1:0]          sc_out,
  input  logic                      sc_write
);

  localparam int ID_W = $clog2(NREQ);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]     last_gnt_q, last_gnt_d;
  logic                last_q, last_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NREQ-1:0]     req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   sc_instring_q, sc_instring_d;
  logic                sc_enable_q, sc_enable_d;
  logic                sc_reset_q, sc_reset_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic [NREQ-1:0]     gnt_onehot;
  logic                issue_hs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  assign gnt_onehot = NREQ'(1) << gnt_id_q;
  assign issue_hs   = req_ready_q[gnt_id_q] & req_valid[gnt_id_q];

  always_comb begin
    state_d       = state_q;
    gnt_id_d      = gnt_id_q;
    last_gnt_d    = last_gnt_q;
    last_d        = last_q;
    timer_d       = timer_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_err_d     = rsp_err_q;
    sc_instring_d = sc_instring_q;
    sc_enable_d   = sc_enable_q;
    sc_reset_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          gnt_id_d   = arb_idx;
          sc_reset_d = 1'b1;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Ready is raised on entry to ISSUE so it is a registered output.
        req_ready_d = gnt_onehot;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The grant is held here until the owner offers a chunk.
        if (issue_hs) begin
          req_ready_d   = '0;
          sc_instring_d = req_data[int'(gnt_id_q)*DATA_W +: DATA_W];
          last_d        = req_last[gnt_id_q];
          timer_d       = '0;
          sc_enable_d   = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (sc_write) begin
          rsp_data_d  = sc_out;
          rsp_err_d   = 1'b0;
          rsp_id_d    = gnt_id_q;
          rsp_valid_d = 1'b1;
          sc_enable_d = 1'b0;
          state_d     = ST_RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = gnt_id_q;
          rsp_valid_d = 1'b1;
          sc_enable_d = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (last_q) begin
            last_gnt_d = gnt_id_q;
            state_d    = ST_IDLE;
          end else if (rsp_err_q) begin
            // Counter state is unknown after a timeout: clear it, keep grant.
            sc_reset_d = 1'b1;
            state_d    = ST_FLUSH;
          end else begin
            req_ready_d = gnt_onehot;
            state_d     = ST_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      gnt_id_q      <= '0;
      last_gnt_q    <= ID_W'(NREQ - 1);
      last_q        <= 1'b0;
      timer_q       <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_err_q     <= 1'b0;
      sc_instring_q <= '0;
      sc_enable_q   <= 1'b0;
      sc_reset_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_id_q      <= gnt_id_d;
      last_gnt_q    <= last_gnt_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      sc_instring_q <= sc_instring_d;
      sc_enable_q   <= sc_enable_d;
      sc_reset_q    <= sc_reset_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_err     = rsp_err_q;
  assign sc_instring = sc_instring_q;
  assign sc_enable   = sc_enable_q;
  assign sc_reset    = sc_reset_q;

endmodule

`default_nettype wire

// File: tb/tb_string_counter_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_string_counter_sched
// Purpose : Self-checking bench for string_counter_sched with a stub
//           StringCounter that pulses write a set number of cycles after
//           enable rises (or never, to provoke a timeout).
// Ports   : none
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_string_counter_sched;

  localparam int NREQ    = 2;
  localparam int DATA_W  = 128;
  localparam int OUT_W   = 160;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [OUT_W-1:0]       rsp_data;
  logic [0:0]             rsp_id;
  logic                   rsp_err;
  logic [DATA_W-1:0]      sc_instring;
  logic                   sc_enable;
  logic                   sc_reset;
  logic [OUT_W-1:0]       sc_out;
  logic                   sc_write;

  string_counter_sched #(
    .NREQ(NREQ), .DATA_W(DATA_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .sc_instring(sc_instring), .sc_enable(sc_enable), .sc_reset(sc_reset),
    .sc_out(sc_out), .sc_write(sc_write)
  );

  always #5 clk = ~clk;

  // Stub counter: write is high stub_lat cycles after the first enable cycle.
  int               stub_lat = 2;
  logic [OUT_W-1:0] stub_out = '0;
  int               en_cnt   = 0;
  assign sc_out = stub_out;

  always @(posedge clk) begin
    if (sc_enable) begin
      sc_write <= (stub_lat != 0) && (en_cnt == stub_lat - 1);
      en_cnt   <= en_cnt + 1;
    end else begin
      sc_write <= 1'b0;
      en_cnt   <= 0;
    end
  end

  // Monitors with their own counters, read back by the main sequence.
  int   rst_pulses  = 0;
  int   double_rst  = 0;
  int   onehot_viol = 0;
  int   lock_viol   = 0;
  logic lock_watch  = 1'b0;
  logic prev_rst    = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sc_reset) rst_pulses++;
      if (sc_reset && prev_rst) double_rst++;
      if ($countones(req_ready) > 1) onehot_viol++;
      if (lock_watch && req_ready[1]) lock_viol++;
    end
    prev_rst = sc_reset;
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [OUT_W-1:0] act,
                              input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int               id;
    logic [DATA_W-1:0] data;
    logic             last;
    int               lat;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] exp_data;
    logic             exp_err;
    int               exp_wait;
  } vec_t;

  vec_t vecs [6];

  // Offer one chunk, wait for acceptance, then collect and check the result.
  task automatic run_chunk(input int id, input logic [DATA_W-1:0] data,
                           input logic last, input int lat,
                           input logic [OUT_W-1:0] out,
                           input logic [OUT_W-1:0] exp_data,
                           input logic exp_err, input int exp_wait,
                           input int bp);
    int n;
    int en;
    int diffs;
    logic [OUT_W-1:0] cap_data;
    logic             cap_err;
    logic [0:0]       cap_id;
    stub_lat = lat;
    stub_out = out;
    req_data[id*DATA_W +: DATA_W] = data;
    req_last[id]  = last;
    req_valid[id] = 1'b1;
    n = 0;
    while (!req_ready[id] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", {159'b0, req_ready[id]}, 1);
    if (exp_wait >= 0) chk("ready_latency", n, exp_wait);
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("instring", sc_instring, data);
    en = 0;
    n  = 0;
    while (!rsp_valid && n < 100) begin
      if (sc_enable) en++;
      @(negedge clk);
      n++;
    end
    chk("enable_cycles", en, (lat == 0) ? TIMEOUT : lat + 1);
    chk("rsp_valid", {159'b0, rsp_valid}, 1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_id", {159'b0, rsp_id}, id);
    chk("rsp_err", {159'b0, rsp_err}, {159'b0, exp_err});
    if (bp > 0) begin
      cap_data = rsp_data;
      cap_err  = rsp_err;
      cap_id   = rsp_id;
      diffs    = 0;
      repeat (bp) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== cap_data || rsp_err !== cap_err ||
            rsp_id !== cap_id) diffs++;
      end
      chk("bp_stable", diffs, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {159'b0, rsp_valid}, 0);
  endtask

  initial begin
    int n;
    int exp_id;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;

    vecs[0] = '{0, {56'h0, "AAABBBCCC"}, 1'b0, 2, 160'h1, 160'h1, 1'b0, 2};
    vecs[1] = '{0, {56'h0, "xxxxxxxxx"}, 1'b1, 2, 160'h2, 160'h2, 1'b0, 0};
    vecs[2] = '{1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 3,
                160'h33, 160'h33, 1'b0, 2};
    vecs[3] = '{0, 128'hCAFE, 1'b1, 1, 160'hDEAD_BEEF_0000_0000_0000_0000_1234,
                160'hDEAD_BEEF_0000_0000_0000_0000_1234, 1'b0, 2};
    vecs[4] = '{1, 128'h9999, 1'b0, 0, 160'h77, 160'h0, 1'b1, 2};
    vecs[5] = '{1, 128'h5A5A, 1'b1, 2, 160'h55, 160'h55, 1'b0, 1};

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", {158'b0, req_ready}, 0);
    chk("rst_rsp_valid", {159'b0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", {159'b0, rsp_id}, 0);
    chk("rst_rsp_err", {159'b0, rsp_err}, 0);
    chk("rst_instring", sc_instring, 0);
    chk("rst_enable", {159'b0, sc_enable}, 0);
    chk("rst_screset", {159'b0, sc_reset}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: sequences, back-to-back chunk, timeout with re-flush
    for (int i = 0; i < 6; i++)
      run_chunk(vecs[i].id, vecs[i].data, vecs[i].last, vecs[i].lat,
                vecs[i].out, vecs[i].exp_data, vecs[i].exp_err,
                vecs[i].exp_wait, 0);
    chk("flush_count_tbl", rst_pulses, 5);
    chk("idle_ready", {158'b0, req_ready}, 0);
    chk("idle_enable", {159'b0, sc_enable}, 0);

    // Round robin: both continuously valid, single-chunk sequences
    d0 = 128'hA0A0;
    d1 = 128'hB1B1;
    req_data  = {d1, d0};
    req_last  = 2'b11;
    req_valid = 2'b11;
    stub_lat  = 2;
    for (int k = 0; k < 4; k++) begin
      exp_id   = k % 2;
      stub_out = 160'(k + 10);
      n = 0;
      while (req_ready == 2'b00 && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", {158'b0, req_ready}, (exp_id == 0) ? 1 : 2);
      @(negedge clk);
      chk("rr_instring", sc_instring, (exp_id == 0) ? d0 : d1);
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rr_rsp_id", {159'b0, rsp_id}, exp_id);
      chk("rr_rsp_data", rsp_data, 160'(k + 10));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    req_valid = 2'b00;
    chk("flush_count_rr", rst_pulses, 9);

    // Grant lock: requester 0 stalls mid-sequence, requester 1 waits
    run_chunk(0, 128'h0101, 1'b0, 2, 160'h61, 160'h61, 1'b0, 2, 0);
    lock_watch   = 1'b1;
    req_last[1]  = 1'b1;
    req_data[DATA_W +: DATA_W] = 128'h0202;
    req_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("lock_ready", {158'b0, req_ready}, 1);
    run_chunk(0, 128'h0303, 1'b1, 2, 160'h62, 160'h62, 1'b0, 0, 0);
    lock_watch = 1'b0;
    chk("lock_viol", lock_viol, 0);
    run_chunk(1, 128'h0202, 1'b1, 2, 160'h63, 160'h63, 1'b0, 2, 0);

    // Backpressure: result fields hold for 10 cycles
    run_chunk(0, 128'h0404, 1'b1, 2, 160'h64, 160'h64, 1'b0, 2, 10);

    // Reset during WAIT; requester 0 must win afterwards
    stub_lat = 0;
    req_data[DATA_W +: DATA_W] = 128'h0505;
    req_last  = 2'b10;
    req_valid = 2'b10;
    n = 0;
    while (!req_ready[1] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ready", {158'b0, req_ready}, 2);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("mid_enable", {159'b0, sc_enable}, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_req_ready", {158'b0, req_ready}, 0);
    chk("ar_rsp_valid", {159'b0, rsp_valid}, 0);
    chk("ar_rsp_data", rsp_data, 0);
    chk("ar_rsp_err", {159'b0, rsp_err}, 0);
    chk("ar_instring", sc_instring, 0);
    chk("ar_enable", {159'b0, sc_enable}, 0);
    chk("ar_screset", {159'b0, sc_reset}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stub_lat  = 2;
    stub_out  = 160'hAB;
    req_data  = {128'h0707, 128'h0606};
    req_last  = 2'b11;
    req_valid = 2'b11;
    n = 0;
    while (req_ready == 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_grant", {158'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_data", rsp_data, 160'hAB);
    chk("post_rst_id", {159'b0, rsp_id}, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    chk("double_reset", double_rst, 0);
    chk("onehot_ready", onehot_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
